// File: rtl/coin_pkg.sv
// ============================================================================
// Module      : coin_pkg
// Description : Shared coin types, emitter states and parameter defaults.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package coin_pkg;

  localparam int DEB_CYC_DEF = 4;
  localparam int QDEPTH_DEF  = 4;
  localparam int GAP_CYC_DEF = 2;

  typedef enum logic {
    COIN_5  = 1'b0,
    COIN_10 = 1'b1
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } emit_state_t;

endpackage

`default_nettype wire

// File: rtl/coin_debounce.sv
// ============================================================================
// Module      : coin_debounce
// Description : Sensor synchronizer, level debouncer and rising-edge event.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module coin_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sens_i,
  output logic event_o
);

  localparam logic [7:0] C_CNT_LAST = 8'(DEB_CYC - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       deb_q;
  logic       deb_d;
  logic       ev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      sync1_q <= sens_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      ev_q    <= deb_d & ~deb_q;
    end
  end

  // The level flips on the DEB_CYC-th consecutive mismatching cycle.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == C_CNT_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign event_o = ev_q;

endmodule

`default_nettype wire

// File: rtl/coin_acceptor.sv
// ============================================================================
// Module      : coin_acceptor
// Description : Two-channel coin acceptor with FIFO queue and pulse emitter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int QDEPTH  = QDEPTH_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sens_a,
  input  logic                      sens_b,
  input  logic                      accept_en,
  output logic                      i,
  output logic                      j,
  output logic                      reject,
  output logic                      q_full,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int         C_AW       = $clog2(QDEPTH);
  localparam int         C_CW       = C_AW + 1;
  localparam logic [3:0] C_GAP_LAST = 4'(GAP_CYC - 1);

  logic w_ev_a;
  logic w_ev_b;

  coin_debounce #(.DEB_CYC(DEB_CYC)) u_deb_a (
    .clk     (clk),
    .rst     (rst),
    .sens_i  (sens_a),
    .event_o (w_ev_a)
  );

  coin_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b (
    .clk     (clk),
    .rst     (rst),
    .sens_i  (sens_b),
    .event_o (w_ev_b)
  );

  coin_t            mem_q [QDEPTH];
  logic [C_AW-1:0]  wr_ptr_q;
  logic [C_AW-1:0]  rd_ptr_q;
  logic [C_CW-1:0]  count_q;
  logic [C_CW-1:0]  count_d;
  logic             full_q;
  logic             reject_q;
  logic             reject_d;

  emit_state_t      state_q;
  emit_state_t      state_d;
  logic [3:0]       gap_q;
  logic [3:0]       gap_d;
  logic             i_q;
  logic             i_d;
  logic             j_q;
  logic             j_d;

  logic             w_single;
  logic             w_dual;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  coin_t            w_type;
  coin_t            w_head;

  assign w_single = w_ev_a ^ w_ev_b;
  assign w_dual   = w_ev_a & w_ev_b;
  assign w_type   = w_ev_b ? COIN_10 : COIN_5;
  assign w_full   = (count_q == C_CW'(QDEPTH));
  assign w_pop    = (state_q == ST_IDLE) && accept_en && (count_q != '0);
  // A full queue can still take a coin when the head leaves in the same cycle.
  assign w_push   = w_single && (!w_full || w_pop);
  assign w_head   = mem_q[rd_ptr_q];
  assign reject_d = w_dual | (w_single & ~w_push);

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + C_CW'(1);
      2'b01:   count_d = count_q - C_CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_type;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + C_AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + C_AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d == C_CW'(QDEPTH));
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    i_d     = 1'b0;
    j_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_pop) begin
          state_d = ST_DRIVE;
          i_d     = (w_head == COIN_5);
          j_d     = (w_head == COIN_10);
        end
      end
      ST_DRIVE: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == C_GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      i_q     <= 1'b0;
      j_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign i       = i_q;
  assign j       = j_q;
  assign reject  = reject_q;
  assign q_full  = full_q;
  assign q_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Directed self-checking bench for coin_acceptor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sens_a;
  logic       sens_b;
  logic       accept_en;
  logic       i;
  logic       j;
  logic       reject;
  logic       q_full;
  logic [2:0] q_count;

  int checks = 0;
  int passes = 0;

  int cyc   = 0;
  int n_i   = 0;
  int n_j   = 0;
  int n_rej = 0;
  int n_ij  = 0;
  int pcyc[$];
  int ptype[$];

  coin_acceptor dut (
    .clk       (clk),
    .rst       (rst),
    .sens_a    (sens_a),
    .sens_b    (sens_b),
    .accept_en (accept_en),
    .i         (i),
    .j         (j),
    .reject    (reject),
    .q_full    (q_full),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  // Pulse recorder: type 0 = i (5-unit), 1 = j (10-unit).
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (i) begin n_i = n_i + 1; pcyc.push_back(cyc); ptype.push_back(0); end
    if (j) begin n_j = n_j + 1; pcyc.push_back(cyc); ptype.push_back(1); end
    if (reject) n_rej = n_rej + 1;
    if (i && j) n_ij = n_ij + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic coin(input logic a, input logic b, input int hold);
    sens_a = a;
    sens_b = b;
    tick(hold);
    sens_a = 1'b0;
    sens_b = 1'b0;
    tick(12);
  endtask

  task automatic test_reset;
    rst = 1'b1; sens_a = 1'b0; sens_b = 1'b0; accept_en = 1'b0;
    tick(3);
    checks++; if (i !== 1'b0) $display("FAIL reset_i got %b want 0", i); else passes++;
    checks++; if (j !== 1'b0) $display("FAIL reset_j got %b want 0", j); else passes++;
    checks++; if (reject !== 1'b0) $display("FAIL reset_reject got %b want 0", reject); else passes++;
    checks++; if (q_full !== 1'b0) $display("FAIL reset_q_full got %b want 0", q_full); else passes++;
    checks++; if (q_count !== 3'd0) $display("FAIL reset_q_count got %0d want 0", q_count); else passes++;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_a;
    int i0, j0, r0;
    i0 = n_i; j0 = n_j; r0 = n_rej;
    accept_en = 1'b1;
    coin(1'b1, 1'b0, 10);
    tick(10);
    checks++; if (n_i - i0 !== 1) $display("FAIL single_a_i got %0d want 1", n_i - i0); else passes++;
    checks++; if (n_j - j0 !== 0) $display("FAIL single_a_j got %0d want 0", n_j - j0); else passes++;
    checks++; if (n_rej - r0 !== 0) $display("FAIL single_a_reject got %0d want 0", n_rej - r0); else passes++;
    checks++; if (q_count !== 3'd0) $display("FAIL single_a_q_count got %0d want 0", q_count); else passes++;
  endtask

  task automatic test_glitch_b;
    int j0, r0;
    j0 = n_j; r0 = n_rej;
    accept_en = 1'b1;
    coin(1'b0, 1'b1, 2);
    tick(10);
    checks++; if (n_j - j0 !== 0) $display("FAIL glitch_b_j got %0d want 0", n_j - j0); else passes++;
    checks++; if (n_rej - r0 !== 0) $display("FAIL glitch_b_reject got %0d want 0", n_rej - r0); else passes++;
    checks++; if (q_count !== 3'd0) $display("FAIL glitch_b_q_count got %0d want 0", q_count); else passes++;
  endtask

  task automatic test_both;
    int i0, j0, r0;
    i0 = n_i; j0 = n_j; r0 = n_rej;
    accept_en = 1'b1;
    coin(1'b1, 1'b1, 10);
    tick(10);
    checks++; if (n_rej - r0 !== 1) $display("FAIL both_reject got %0d want 1", n_rej - r0); else passes++;
    checks++; if (n_i - i0 !== 0) $display("FAIL both_i got %0d want 0", n_i - i0); else passes++;
    checks++; if (n_j - j0 !== 0) $display("FAIL both_j got %0d want 0", n_j - j0); else passes++;
    checks++; if (q_count !== 3'd0) $display("FAIL both_q_count got %0d want 0", q_count); else passes++;
  endtask

  task automatic test_queue_full;
    int r0, i0, p0;
    r0 = n_rej; i0 = n_i;
    accept_en = 1'b0;
    for (int k = 0; k < 4; k++) coin(1'b1, 1'b0, 10);
    checks++; if (q_count !== 3'd4) $display("FAIL full_q_count got %0d want 4", q_count); else passes++;
    checks++; if (q_full !== 1'b1) $display("FAIL full_q_full got %b want 1", q_full); else passes++;
    checks++; if (n_rej - r0 !== 0) $display("FAIL full_early_reject got %0d want 0", n_rej - r0); else passes++;
    coin(1'b1, 1'b0, 10);
    checks++; if (n_rej - r0 !== 1) $display("FAIL full_fifth_reject got %0d want 1", n_rej - r0); else passes++;
    checks++; if (q_count !== 3'd4) $display("FAIL full_after_fifth got %0d want 4", q_count); else passes++;
    checks++; if (n_i - i0 !== 0) $display("FAIL full_no_emit got %0d want 0", n_i - i0); else passes++;
    p0 = pcyc.size();
    accept_en = 1'b1;
    tick(30);
    checks++; if (n_i - i0 !== 4) $display("FAIL drain_i got %0d want 4", n_i - i0); else passes++;
    checks++; if (q_count !== 3'd0) $display("FAIL drain_q_count got %0d want 0", q_count); else passes++;
    checks++; if (q_full !== 1'b0) $display("FAIL drain_q_full got %b want 0", q_full); else passes++;
    // DRIVE, two GAP cycles, one IDLE pop cycle: pulses repeat every 4 cycles.
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (pcyc.size() < p0 + 4)
        $display("FAIL drain_spacing%0d got %0d pulses want 4", k, pcyc.size() - p0);
      else if (pcyc[p0+k] - pcyc[p0+k-1] !== 4)
        $display("FAIL drain_spacing%0d got %0d want 4", k, pcyc[p0+k] - pcyc[p0+k-1]);
      else passes++;
    end
  endtask

  task automatic test_order;
    int s0;
    int exp_t[3];
    exp_t[0] = 1; exp_t[1] = 0; exp_t[2] = 1;
    accept_en = 1'b0;
    coin(1'b0, 1'b1, 10);
    coin(1'b1, 1'b0, 10);
    coin(1'b0, 1'b1, 10);
    checks++; if (q_count !== 3'd3) $display("FAIL order_q_count got %0d want 3", q_count); else passes++;
    s0 = ptype.size();
    accept_en = 1'b1;
    tick(25);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ptype.size() < s0 + 3)
        $display("FAIL order_pulse%0d got %0d pulses want 3", k, ptype.size() - s0);
      else if (ptype[s0+k] !== exp_t[k])
        $display("FAIL order_pulse%0d got type %0d want %0d", k, ptype[s0+k], exp_t[k]);
      else passes++;
    end
    checks++; if (n_ij !== 0) $display("FAIL i_j_overlap got %0d want 0", n_ij); else passes++;
  endtask

  task automatic test_reset_drive;
    int  i0, j0;
    bit  found;
    accept_en = 1'b0;
    for (int k = 0; k < 3; k++) coin(1'b1, 1'b0, 10);
    checks++; if (q_count !== 3'd3) $display("FAIL rstdrv_queued got %0d want 3", q_count); else passes++;
    accept_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      if (i === 1'b1) found = 1'b1;
    end
    checks++; if (!found) $display("FAIL rstdrv_wait_drive got no i pulse within 20 cycles"); else passes++;
    rst = 1'b1;
    tick(1);
    checks++; if (i !== 1'b0) $display("FAIL rstdrv_i got %b want 0", i); else passes++;
    checks++; if (j !== 1'b0) $display("FAIL rstdrv_j got %b want 0", j); else passes++;
    checks++; if (q_count !== 3'd0) $display("FAIL rstdrv_q_count got %0d want 0", q_count); else passes++;
    rst = 1'b0;
    i0 = n_i; j0 = n_j;
    tick(20);
    checks++; if ((n_i - i0) + (n_j - j0) !== 0)
      $display("FAIL rstdrv_no_pulses got %0d want 0", (n_i - i0) + (n_j - j0)); else passes++;
  endtask

  initial begin
    test_reset;
    test_single_a;
    test_glitch_b;
    test_both;
    test_queue_full;
    test_order;
    test_reset_drive;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
